// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing 1-cycle-latency imem reads into a 2-entry {instr, pc} queue for decode.
module fetch_stage #(
  parameter int WORD = 32,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic [WORD-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [WORD-1:0] redirect_pc,
  input  logic            halt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_instr,
  output logic [WORD-1:0] out_pc,
  output logic            halted
);
  localparam logic [2:0] DEPTH_W = 3'(DEPTH);
  logic [WORD-1:0] pc, inflight_pc, redir_pc;
  logic [WORD-1:0] q_instr [2];
  logic [WORD-1:0] q_pc [2];
  logic [1:0] count;
  logic [2:0] occ;
  logic inflight, rd, wr, pop, push, issue;
  always_comb begin
    redir_pc = {redirect_pc[WORD-1:2], 2'b00};
    out_valid = count != 2'd0;
    pop = out_valid & out_ready;
    push = inflight & !redirect_valid;
    occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    issue = rst_n & !halt & (redirect_valid | (occ < DEPTH_W));
    imem_req = issue;
    imem_addr = redirect_valid ? redir_pc : pc;
    halted = rst_n & halt & (count == 2'd0) & !inflight;
    out_instr = q_instr[rd];
    out_pc = q_pc[rd];
  end
  // A redirect drops the queue and any arriving response, then restarts from the aligned target.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      count <= 2'd0;
      rd <= 1'b0;
      wr <= 1'b0;
      q_instr <= '{default: '0};
      q_pc <= '{default: '0};
    end else if (redirect_valid) begin
      count <= 2'd0;
      rd <= 1'b0;
      wr <= 1'b0;
      inflight <= issue;
      inflight_pc <= redir_pc;
      pc <= issue ? redir_pc + WORD'(4) : redir_pc;
    end else begin
      if (push) begin
        q_instr[wr] <= imem_rdata;
        q_pc[wr] <= inflight_pc;
        wr <= ~wr;
      end
      if (pop) rd <= ~rd;
      count <= count + {1'b0, push} - {1'b0, pop};
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc <= pc + WORD'(4);
      end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard of expected pcs consumed on each decode handshake.
module tb_fetch_stage;
  localparam logic [31:0] K = 32'hA5C3_0F96;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, redirect_valid = 1'b0, halt = 1'b0, out_valid, out_ready = 1'b1, halted;
  logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0, out_instr, out_pc;
  int total = 0, bad = 0, pops = 0, p0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr ^ K;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  always begin
    @(negedge clk);
    #3;
    if (rst_n && out_valid && out_ready) begin
      pops++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_out observed=%h expected=none", out_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e);
        check("sb_instr", out_instr, e ^ K);
      end
    end
  end

  initial begin
    #12;
    check("rst_req", 32'(imem_req), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);
    expect_seq(32'h0, 200);
    step();
    rst_n = 1'b1;
    #1;
    check("t1_req0", 32'(imem_req), 1);
    check("t1_addr0", imem_addr, 32'h0);
    check("t1_valid0", 32'(out_valid), 0);
    step(); #1;
    check("t1_addr1", imem_addr, 32'h4);
    check("t1_valid1", 32'(out_valid), 0);
    step(); #1;
    check("t1_valid2", 32'(out_valid), 1);
    check("t1_pc2", out_pc, 32'h0);
    check("t1_addr2", imem_addr, 32'h8);
    p0 = pops;
    step(8); #1;
    check("t1_thru", 32'(pops - p0), 8);
    // back-pressure
    step();
    out_ready = 1'b0;
    #1;
    e = exp_q[0];
    check("t2_req_stop", 32'(imem_req), 0);
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      check("t2_hold_pc", out_pc, e);
      check("t2_hold_instr", out_instr, e ^ K);
      check("t2_req_low", 32'(imem_req), 0);
    end
    out_ready = 1'b1;
    p0 = pops;
    step(6); #1;
    check("t2_thru", 32'(pops - p0), 6);
    // redirect with a response in flight
    step();
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    #1;
    check("t3_req", 32'(imem_req), 1);
    check("t3_addr", imem_addr, 32'h100);
    expect_seq(32'h100, 100);
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t3_flushed", 32'(out_valid), 0);
    check("t3_addr_next", imem_addr, 32'h104);
    step(); #1;
    check("t3_first", out_pc, 32'h100);
    step(); #1;
    check("t3_second", out_pc, 32'h104);
    step(2);
    // halt mid-stream
    halt = 1'b1;
    #1;
    check("t4_req_off", 32'(imem_req), 0);
    check("t4_not_halted", 32'(halted), 0);
    step(); #1;
    check("t4_req_off1", 32'(imem_req), 0);
    check("t4_draining", 32'(halted), 0);
    step(); #1;
    check("t4_empty", 32'(out_valid), 0);
    check("t4_halted", 32'(halted), 1);
    step(); #1;
    check("t4_still_halted", 32'(halted), 1);
    check("t4_req_still_off", 32'(imem_req), 0);
    halt = 1'b0;
    #1;
    check("t4_resume_req", 32'(imem_req), 1);
    check("t4_resume_addr", imem_addr, exp_q[0]);
    check("t4_unhalted", 32'(halted), 0);
    step(3);
    // halt together with redirect
    halt = 1'b1;
    step(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h202;
    #1;
    check("t4b_req", 32'(imem_req), 0);
    check("t4b_halted", 32'(halted), 1);
    expect_seq(32'h200, 100);
    step();
    redirect_valid = 1'b0;
    halt = 1'b0;
    #1;
    check("t4b_req_on", 32'(imem_req), 1);
    check("t4b_addr", imem_addr, 32'h200);
    step(4);
    // wrap at the top of the address space
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    #1;
    check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    expect_seq(32'hFFFF_FFFC, 100);
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t5_addr_wrap", imem_addr, 32'h0);
    step(); #1;
    check("t5_top_out", out_pc, 32'hFFFF_FFFC);
    step(); #1;
    check("t5_wrap_out", out_pc, 32'h0);
    step(3);
    // asynchronous reset away from the clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 0);
    check("t5_rst_req", 32'(imem_req), 0);
    check("t5_rst_pc", out_pc, 0);
    check("t5_rst_halted", 32'(halted), 0);
    step(2);
    expect_seq(32'h0, 100);
    rst_n = 1'b1;
    #1;
    check("t5_restart_req", 32'(imem_req), 1);
    check("t5_restart_addr", imem_addr, 32'h0);
    step(2); #1;
    check("t5_restart_out", out_pc, 32'h0);
    step(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
